water_level_array: RTL and testbench
====================================

# water_level_array

Multi-channel float-switch conditioner for the tank level sensors, stacked from bottom (channel 0) to top. Each channel is synchronised, debounced, and monitored for chatter. The block derives a contiguous fill level and a sensor-ordering fault for the filter control FSM. All outputs are registered.

## Interface
- CHANNELS, 4: number of level sensors; channel 0 is the lowest. Must be ≥ 1.
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- STABLE_MS, 20: debounce time in ms. COUNTER_LIMIT = (CLK_FREQ/1000)*STABLE_MS, must be ≥ 1.
- CHATTER_LIMIT, 8: aborted qualifications before a channel's chatter fault sets. Must be ≥ 1.
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- level_async  in  CHANNELS  raw sensor inputs; 1 = dry/empty, 0 = wet.
- fault_clear  in  1  synchronous pulse that clears all chatter faults and abort counters.
- level_stable  out  CHANNELS  debounced sensor state.
- change_pulse  out  CHANNELS  one-cycle strobe per channel when level_stable toggles.
- level_count  out  $clog2(CHANNELS+1)  number of contiguous wet channels counted from channel 0.
- order_fault  out  1  wet pattern is not a thermometer code (a wet sensor sits above a dry one).
- chatter_fault  out  CHANNELS  sticky per-channel chatter flag.

## Operation
- Reset values (reset = 0, applied immediately): sync stages all 1, level_stable all 1, change_pulse 0, level_count 0, order_fault 0, chatter_fault 0, all counters 0.
- Synchroniser: two flip-flop stages per channel, both reset to 1. Call the second stage sync[i].
- Debounce counter: one per channel, width $clog2(COUNTER_LIMIT+1).
  - If sync[i] ≠ level_stable[i] and counter < COUNTER_LIMIT-1: increment the counter.
  - If sync[i] ≠ level_stable[i] and counter = COUNTER_LIMIT-1: on the next edge, level_stable[i] takes sync[i], the counter goes to 0, and change_pulse[i] = 1 for that one cycle.
  - If sync[i] = level_stable[i]: the counter goes to 0.
- Abort: sync[i] = level_stable[i] while counter ≠ 0 is an aborted qualification.
  - Each abort increments abort_cnt[i], which saturates at CHATTER_LIMIT.
  - When abort_cnt[i] reaches CHATTER_LIMIT, chatter_fault[i] sets on that same edge.
  - A successful flip clears abort_cnt[i]. It does not clear chatter_fault.
- fault_clear = 1 clears every abort_cnt and every chatter_fault. If a threshold is hit on the same edge, set wins and the fault stays 1 (no lost fault).
- Debouncing continues normally while chatter_fault is set. The flag is informational only.
- Derived outputs, computed from level_stable and registered:
  - level_count = number of consecutive wet (0) bits starting at channel 0.
  - order_fault = 1 if any wet bit exists above the first dry bit.
  - Both are non-sticky.

## Timing
- Input to level_stable: an input step that holds produces its level_stable change COUNTER_LIMIT+2 edges after the first edge that samples the new value (2 synchroniser stages plus COUNTER_LIMIT mismatch cycles).
- change_pulse is high exactly in the first cycle the new level_stable value is visible.
- level_count and order_fault lag level_stable by one cycle.
- A glitch shorter than COUNTER_LIMIT cycles at sync never changes level_stable. It counts one abort.
- Channels are fully independent. Simultaneous flips on several channels each pulse in the same cycle.
- Reset asserted mid-qualification discards all progress. After release, the full COUNTER_LIMIT+2 latency applies again.

## Test plan
Use CLK_FREQ=1000, STABLE_MS=5 (COUNTER_LIMIT=5), CHANNELS=4, CHATTER_LIMIT=3.
- Reset: hold reset=0 with inputs=4'b0000 -> level_stable=4'b1111, level_count=0, order_fault=0, chatter_fault=0, no change_pulse.
- Clean step: after reset, drive ch0 to 0 and hold -> level_stable[0] falls exactly 7 edges later, change_pulse[0] high one cycle, level_count=1 one cycle after that.
- Glitch rejection: 3-cycle low pulse on ch1 (repeat 3 times, each separated by 10 idle cycles) -> level_stable unchanged, chatter_fault[1] sets at the third abort; fault_clear -> chatter_fault[1]=0.
- Set-wins collision: pulse fault_clear on the same edge as the third abort -> chatter_fault stays 1.
- Ordering: stable pattern ch2 wet, ch0/ch1 dry (4'b1011) -> order_fault=1, level_count=0. Then wet ch0 and ch1 (4'b1000) -> order_fault=0, level_count=3.
- Reset mid-operation: assert reset at counter=3 of a ch3 qualification -> level_stable[3]=1. After release, the change appears only after the full 7-edge latency.

Source files
------------

// File: rtl/water_level_array.sv
`default_nettype none
// ============================================================================
// water_level_array
// Float-switch conditioner: per-channel sync, debounce and chatter monitor,
// plus a registered contiguous fill level and sensor-ordering fault.
// Revision: 1.0
// ============================================================================
module water_level_array #(
   parameter int  CHANNELS      = 4,
   parameter int  CLK_FREQ      = 50_000_000,
   parameter int  STABLE_MS     = 20,
   parameter int  CHATTER_LIMIT = 8,
   localparam int COUNT_W       = $clog2(CHANNELS + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] level_async,
   input  logic                fault_clear,
   output logic [CHANNELS-1:0] level_stable,
   output logic [CHANNELS-1:0] change_pulse,
   output logic [COUNT_W-1:0]  level_count,
   output logic                order_fault,
   output logic [CHANNELS-1:0] chatter_fault
);

   localparam int COUNTER_LIMIT = (CLK_FREQ / 1000) * STABLE_MS;
   localparam int CNT_W         = $clog2(COUNTER_LIMIT + 1);
   localparam int ABT_W         = $clog2(CHATTER_LIMIT + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNTER_LIMIT - 1);
   localparam logic [ABT_W-1:0] ABT_MAX  = ABT_W'(CHATTER_LIMIT);
   localparam logic [ABT_W-1:0] ABT_LAST = ABT_W'(CHATTER_LIMIT - 1);

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
         logic [1:0]       sync_q;
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic             stable_q, stable_d;
         logic             pulse_q, pulse_d;
         logic [ABT_W-1:0] abt_q, abt_d;
         logic             flt_q, flt_d;
         logic             mismatch;
         logic             abort;
         logic             hit;

         always_comb begin
            mismatch = sync_q[1] ^ stable_q;
            cnt_d    = '0;
            stable_d = stable_q;
            pulse_d  = 1'b0;
            abort    = 1'b0;
            if (mismatch) begin
               if (cnt_q == CNT_LAST) begin
                  stable_d = sync_q[1];
                  pulse_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (cnt_q != '0) begin
               abort = 1'b1;
            end
         end

         // A threshold hit on the same edge as fault_clear still sets the flag.
         always_comb begin
            hit   = abort && (abt_q == ABT_LAST);
            abt_d = abt_q;
            if (fault_clear || pulse_d) begin
               abt_d = '0;
            end else if (abort && (abt_q != ABT_MAX)) begin
               abt_d = abt_q + ABT_W'(1);
            end
            flt_d = fault_clear ? 1'b0 : flt_q;
            if (hit) begin
               flt_d = 1'b1;
            end
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               sync_q   <= 2'b11;
               cnt_q    <= '0;
               stable_q <= 1'b1;
               pulse_q  <= 1'b0;
               abt_q    <= '0;
               flt_q    <= 1'b0;
            end else begin
               sync_q   <= {sync_q[0], level_async[i]};
               cnt_q    <= cnt_d;
               stable_q <= stable_d;
               pulse_q  <= pulse_d;
               abt_q    <= abt_d;
               flt_q    <= flt_d;
            end
         end

         assign level_stable[i]  = stable_q;
         assign change_pulse[i]  = pulse_q;
         assign chatter_fault[i] = flt_q;
      end
   endgenerate

   logic [COUNT_W-1:0] count_q, count_d;
   logic               order_q, order_d;
   logic               dry_seen;

   always_comb begin
      count_d  = '0;
      order_d  = 1'b0;
      dry_seen = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (!level_stable[i]) begin
            if (dry_seen) begin
               order_d = 1'b1;
            end else begin
               count_d = count_d + COUNT_W'(1);
            end
         end else begin
            dry_seen = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         order_q <= 1'b0;
      end else begin
         count_q <= count_d;
         order_q <= order_d;
      end
   end

   assign level_count = count_q;
   assign order_fault = order_q;

endmodule
`default_nettype wire

// File: tb/tb_water_level_array.sv
`default_nettype none
// ============================================================================
// tb_water_level_array
// Directed bench: table of steady patterns plus hand-built timing sequences.
// Revision: 1.0
// ============================================================================
module tb_water_level_array;

   logic       clk;
   logic       reset;
   logic [3:0] level_async;
   logic       fault_clear;
   logic [3:0] level_stable;
   logic [3:0] change_pulse;
   logic [2:0] level_count;
   logic       order_fault;
   logic [3:0] chatter_fault;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0] lvl;
      logic [3:0] stable;
      logic [2:0] count;
      logic       ord;
   } vec_t;

   vec_t tbl [7];

   water_level_array #(
      .CHANNELS     (4),
      .CLK_FREQ     (1000),
      .STABLE_MS    (5),
      .CHATTER_LIMIT(3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .level_async  (level_async),
      .fault_clear  (fault_clear),
      .level_stable (level_stable),
      .change_pulse (change_pulse),
      .level_count  (level_count),
      .order_fault  (order_fault),
      .chatter_fault(chatter_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, required finish before 200000");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Three-cycle low pulse on one channel; its abort lands on the 6th edge.
   task automatic glitch(input int ch, input bit clr_at_abort);
      level_async[ch] = 1'b0;
      repeat (3) @(negedge clk);
      level_async[ch] = 1'b1;
      repeat (2) @(negedge clk);
      if (clr_at_abort) fault_clear = 1'b1;
      @(negedge clk);
      fault_clear = 1'b0;
   endtask

   initial begin
      tbl[0] = '{4'b1011, 4'b1011, 3'd0, 1'b1};
      tbl[1] = '{4'b1000, 4'b1000, 3'd3, 1'b0};
      tbl[2] = '{4'b0000, 4'b0000, 3'd4, 1'b0};
      tbl[3] = '{4'b0110, 4'b0110, 3'd1, 1'b1};
      tbl[4] = '{4'b0101, 4'b0101, 3'd0, 1'b1};
      tbl[5] = '{4'b1100, 4'b1100, 3'd2, 1'b0};
      tbl[6] = '{4'b1111, 4'b1111, 3'd0, 1'b0};

      reset       = 1'b0;
      level_async = 4'b0000;
      fault_clear = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_stable",  32'(level_stable),  32'hF);
      chk("rst_count",   32'(level_count),   32'h0);
      chk("rst_order",   32'(order_fault),   32'h0);
      chk("rst_chatter", 32'(chatter_fault), 32'h0);
      chk("rst_pulse",   32'(change_pulse),  32'h0);
      level_async = 4'b1111;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_stable", 32'(level_stable), 32'hF);

      // Clean step on ch0
      level_async[0] = 1'b0;
      repeat (6) @(negedge clk);
      chk("step_early_stable", 32'(level_stable), 32'hF);
      chk("step_early_pulse",  32'(change_pulse), 32'h0);
      @(negedge clk);
      chk("step_stable", 32'(level_stable), 32'hE);
      chk("step_pulse",  32'(change_pulse), 32'h1);
      chk("step_count_lag", 32'(level_count), 32'h0);
      @(negedge clk);
      chk("step_pulse_off", 32'(change_pulse), 32'h0);
      chk("step_count", 32'(level_count), 32'h1);
      chk("step_order", 32'(order_fault), 32'h0);

      // Glitch rejection on ch1
      for (int g = 0; g < 3; g++) begin
         glitch(1, 1'b0);
         repeat (10) @(negedge clk);
         chk("glitch_stable", 32'(level_stable), 32'hE);
         chk("glitch_chatter", 32'(chatter_fault), (g == 2) ? 32'h2 : 32'h0);
      end
      fault_clear = 1'b1;
      @(negedge clk);
      fault_clear = 1'b0;
      chk("clear_chatter", 32'(chatter_fault), 32'h0);

      // Set wins over a coincident clear
      glitch(1, 1'b0);
      repeat (10) @(negedge clk);
      glitch(1, 1'b0);
      repeat (10) @(negedge clk);
      chk("coll_pre_chatter", 32'(chatter_fault), 32'h0);
      glitch(1, 1'b1);
      chk("coll_chatter", 32'(chatter_fault), 32'h2);
      repeat (10) @(negedge clk);
      chk("coll_chatter_hold", 32'(chatter_fault), 32'h2);
      fault_clear = 1'b1;
      @(negedge clk);
      fault_clear = 1'b0;
      chk("coll_clear", 32'(chatter_fault), 32'h0);

      // Simultaneous flips on ch0 and ch2
      level_async = 4'b1011;
      repeat (7) @(negedge clk);
      chk("multi_stable", 32'(level_stable), 32'hB);
      chk("multi_pulse",  32'(change_pulse), 32'h5);

      for (int v = 0; v < 7; v++) begin
         level_async = tbl[v].lvl;
         repeat (8) @(negedge clk);
         chk($sformatf("tbl%0d_stable", v),  32'(level_stable),  32'(tbl[v].stable));
         chk($sformatf("tbl%0d_count", v),   32'(level_count),   32'(tbl[v].count));
         chk($sformatf("tbl%0d_order", v),   32'(order_fault),   32'(tbl[v].ord));
         chk($sformatf("tbl%0d_pulse", v),   32'(change_pulse),  32'h0);
         chk($sformatf("tbl%0d_chatter", v), 32'(chatter_fault), 32'h0);
      end

      // Reset while ch3 qualification has reached count 3
      level_async = 4'b0111;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_stable", 32'(level_stable), 32'hF);
      chk("midrst_pulse",  32'(change_pulse), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      chk("midrst_early_stable", 32'(level_stable), 32'hF);
      @(negedge clk);
      chk("midrst_stable_after", 32'(level_stable), 32'h7);
      chk("midrst_pulse_after",  32'(change_pulse), 32'h8);
      @(negedge clk);
      chk("midrst_order", 32'(order_fault), 32'h1);
      chk("midrst_count", 32'(level_count), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
